fifo_sync_flags: RTL and testbench

- Single-clock, synchronous first-in/first-out buffer: 8 entries of 8-bit data.
- Independent write and read enables.
- Registered read data.
- Four status flags: empty, almost-empty, almost-full, full.
- Sits between a byte producer and a byte consumer in the same clock domain; it absorbs bursts and gives the producer back-pressure through the flags.

---
 rtl/fifo_pkg.sv | 60 ++++++
 rtl/fifo_mem.sv | 58 +++++
 rtl/fifo_sync_flags.sv | 129 ++++++++++++
 tb/tb_fifo_sync_flags.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the single-clock byte FIFO.
//
// Contents:
//   DATA_WIDTH, ADDR_WIDTH, DEPTH   default geometry (8 x 8-bit)
//   AFULL_LEVEL, AEMPTY_LEVEL       default status-flag thresholds
//   fifo_op_e                       accepted-operation classification
//   fifo_flags_t                    bundle of the four status flags
//   FLAGS_RESET                     flag values while / after reset
//   decode_flags()                  occupancy -> status flags
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int ADDR_WIDTH   = 3;
    localparam int DEPTH        = 2 ** ADDR_WIDTH;
    localparam int AFULL_LEVEL  = DEPTH - 1;
    localparam int AEMPTY_LEVEL = 1;

    // Encoding is {write accepted, read accepted} so the accept bits can be
    // cast straight into the enum.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        empty:        1'b1,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        full:         1'b0
    };

    // Status flags as a pure function of occupancy. Thresholds are passed in
    // so a parameterised instance can move them without touching the package.
    function automatic fifo_flags_t decode_flags(
        input int occupancy,
        input int depth,
        input int afull_level,
        input int aempty_level
    );
        fifo_flags_t flags;
        flags.empty        = (occupancy == 0);
        flags.almost_empty = (occupancy <= aempty_level);
        flags.almost_full  = (occupancy >= afull_level);
        flags.full         = (occupancy == depth);
        return flags;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port register array with a synchronous write port and a
// synchronous, registered read port. The read register holds its value when
// no read is requested and clears on reset; the array itself is not reset.
//
// Ports:
//   clk    in   1           clock, rising edge
//   reset  in   1           asynchronous active-high reset (read register only)
//   we     in   1           write enable
//   waddr  in   ADDR_WIDTH  write address
//   wdata  in   DATA_WIDTH  write data
//   re     in   1           read enable
//   raddr  in   ADDR_WIDTH  read address
//   rdata  out  DATA_WIDTH  registered read data
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int L_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [L_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, and leaving the array unreset lets it map onto
    // plain register files or distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking assignment here means a read and a write to the
    // same address in one cycle return the old contents, which is exactly
    // what the full-with-simultaneous-read case needs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : fifo_mem

// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
// Single-clock first-in/first-out byte buffer with registered read data and
// four registered status flags. Placed between a producer and a consumer in
// the same clock domain; the flags give the producer back-pressure.
//
// Ports:
//   clk             in   1           sole clock, rising edge
//   reset           in   1           asynchronous active-high reset
//   data_in         in   DATA_WIDTH  write data, taken when a write is accepted
//   enable_wr       in   1           write request
//   enable_rd       in   1           read request
//   data_out        out  DATA_WIDTH  read data, valid the edge after the read
//   f_empty         out  1           occupancy == 0
//   f_full          out  1           occupancy == DEPTH
//   f_almost_full   out  1           occupancy >= AFULL_LEVEL
//   f_almost_empty  out  1           occupancy <= AEMPTY_LEVEL
//
// Accept rules:
//   read  accepted when requested and not empty (no fall-through on empty)
//   write accepted when requested and not full, or when full but a read is
//   accepted in the same cycle (the freed slot is reused at once)
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
    parameter int AFULL_LEVEL  = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_LEVEL = fifo_pkg::AEMPTY_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enable_wr,
    input  logic                  enable_rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  f_empty,
    output logic                  f_full,
    output logic                  f_almost_full,
    output logic                  f_almost_empty
);

    import fifo_pkg::*;

    localparam int L_DEPTH = 2 ** ADDR_WIDTH;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    fifo_flags_t           r_flags;

    // -------------------------------------------------------------------------
    // Accept decode
    // -------------------------------------------------------------------------
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    fifo_flags_t           w_flags_nxt;

    // Read acceptance is decided first because a full FIFO only takes a
    // write when a read frees a slot in the same cycle.
    assign w_rd_acc = enable_rd & ~r_flags.empty;
    assign w_wr_acc = enable_wr & (~r_flags.full | w_rd_acc);
    assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});

    // NOTE: every output of this block gets a value on every path (default
    // assignment first), so no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WRITE: w_count_nxt = r_count + 1'b1;
            OP_READ:  w_count_nxt = r_count - 1'b1;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Flags are computed from the next occupancy and registered alongside
    // the count, so the outputs come straight from flops and never glitch.
    assign w_flags_nxt = decode_flags(int'(w_count_nxt), L_DEPTH,
                                      AFULL_LEVEL, AEMPTY_LEVEL);

    // -------------------------------------------------------------------------
    // Pointers, count, flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flags  <= FLAGS_RESET;
        end else begin
            // Pointers wrap naturally at 2**ADDR_WIDTH.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Storage with registered read port
    // -------------------------------------------------------------------------
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (data_out)
    );

    assign f_empty        = r_flags.empty;
    assign f_full         = r_flags.full;
    assign f_almost_full  = r_flags.almost_full;
    assign f_almost_empty = r_flags.almost_empty;

endmodule : fifo_sync_flags

// File: tb/tb_fifo_sync_flags.sv
module tb_fifo_sync_flags;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       enable_wr;
    logic       enable_rd;
    logic [7:0] data_out;
    logic       f_empty;
    logic       f_full;
    logic       f_almost_full;
    logic       f_almost_empty;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO contents as a queue plus the expected
    // registered output byte.
    logic [7:0] model_q [$];
    logic [7:0] exp_dout;

    fifo_sync_flags dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .enable_wr      (enable_wr),
        .enable_rd      (enable_rd),
        .data_out       (data_out),
        .f_empty        (f_empty),
        .f_full         (f_full),
        .f_almost_full  (f_almost_full),
        .f_almost_empty (f_almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of occupancy.
    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        check({tag, " data_out"},       data_out,             exp_dout);
        check({tag, " f_empty"},        8'(f_empty),          8'(n == 0));
        check({tag, " f_full"},         8'(f_full),           8'(n == 8));
        check({tag, " f_almost_full"},  8'(f_almost_full),    8'(n >= 7));
        check({tag, " f_almost_empty"}, 8'(f_almost_empty),   8'(n <= 1));
    endtask

    // One clock cycle of stimulus: drive on the falling edge, confirm the
    // output has not moved before the rising edge, update the model at the
    // rising edge, then check just after it.
    task automatic step(input logic wr, input logic rd, input logic [7:0] din, input string tag);
        logic rd_acc;
        logic wr_acc;
        @(negedge clk);
        enable_wr = wr;
        enable_rd = rd;
        data_in   = din;
        #1;
        check({tag, " pre-edge data_out"}, data_out, exp_dout);
        @(posedge clk);
        rd_acc = rd && (model_q.size() > 0);
        wr_acc = wr && ((model_q.size() < 8) || rd_acc);
        if (rd_acc) exp_dout = model_q.pop_front();
        if (wr_acc) model_q.push_back(din);
        #1;
        check_all(tag);
    endtask

    logic [7:0] fill_bytes [8];

    initial begin
        fill_bytes = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hAA, 8'hBB, 8'hFF};
        reset     = 1'b0;
        enable_wr = 1'b0;
        enable_rd = 1'b0;
        data_in   = 8'h00;
        exp_dout  = 8'h00;

        // Reset then idle.
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00, "idle");

        // Fill to full with the directed byte pattern.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, fill_bytes[i], "fill");
        check("full after 8 writes", 8'(f_full), 8'd1);

        // Overflow attempt is dropped.
        step(1'b1, 1'b0, 8'h07, "overflow");

        // Drain: original bytes in order, never 0x07.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain order", data_out, fill_bytes[i]);
        end
        // Underflow leaves the last byte on the output.
        step(1'b0, 1'b1, 8'h00, "underflow");
        check("underflow hold", data_out, 8'hFF);

        // Empty with simultaneous write and read: only the write lands.
        step(1'b1, 1'b1, 8'h08, "empty_rw");
        check("empty_rw data_out", data_out, 8'hFF);

        // Top up to full, then simultaneous write and read while full.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "refill");
        step(1'b1, 1'b1, 8'hBB, "full_rw");
        check("full_rw oldest out", data_out, 8'h08);
        check("full_rw stays full", 8'(f_full), 8'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain2");
        check("0xBB read last", data_out, 8'hBB);

        // Interleaved single writes and reads across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)), "wrap_wr");
            step(1'b0, 1'b1, 8'h00, "wrap_rd");
        end

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 8'($urandom_range(0, 255)), "random");
        end

        // Reset asserted mid-stream takes effect without a clock edge.
        step(1'b1, 1'b0, 8'hC3, "pre_reset");
        step(1'b1, 1'b0, 8'h3C, "pre_reset");
        step(1'b0, 1'b1, 8'h00, "pre_reset");
        @(negedge clk);
        enable_wr = 1'b0;
        enable_rd = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_q.delete();
        exp_dout = 8'h00;
        check_all("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Still functional after reset.
        step(1'b1, 1'b0, 8'h5A, "post_reset");
        step(1'b0, 1'b1, 8'h00, "post_reset");
        check("post_reset data", data_out, 8'h5A);

        @(negedge clk);
        enable_wr = 1'b0;
        enable_rd = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_sync_flags
